// File: rtl/capture_pkg.sv
// capture_pkg: definitions shared by the multi-channel capture buffer.
//   state_e : capture FSM encoding (IDLE / CAPTURE / DONE)
//   FMT_*   : readout format codes carried on bw_bits
//   clog2   : ceiling log2, used to size the channel select
package capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam logic [1:0] FMT_ZEXT  = 2'b00;  // zero-extend
    localparam logic [1:0] FMT_SEXT  = 2'b01;  // sign-extend
    localparam logic [1:0] FMT_LJUST = 2'b10;  // left-justify, zero LSBs
    localparam logic [1:0] FMT_OBIN  = 2'b11;  // offset-binary -> two's complement

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port sample store, one channel.
//   clk          : single clock for both ports
//   we/waddr/wdata : write port
//   re/raddr     : read port; rdata is registered (1-cycle latency) and
//                  holds its value while re is low
//   rdata        : read data
module capture_ram
    import capture_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [0:2**ADDR_W-1];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata <= mem_q[raddr];
    end

endmodule

// File: rtl/multi_chan_capture.sv
// multi_chan_capture: N-channel ADC capture buffer with formatted readout.
//   On load, captures DEPTH=2**ADDR_W samples per channel (qualified by
//   din_valid), then allows any channel to be read back word by word.
//   Ports:
//     wrclk, rst            : clock, async active-high reset
//     din, din_valid        : packed samples (ch0 in LSBs) and qualifier
//     load                  : (re)start capture
//     rden, rd_ch, bw_bits  : read request, channel and format (sampled together)
//     rd_rewind             : read pointer back to 0, clears rd_done
//     test_mode             : only with CAPTURE_TEST_PATTERN_EN; channel k
//                             stores (wr_addr+k) instead of din
//     dout, dout_valid      : formatted word, valid 2 cycles after rden
//     busy, full, rd_done   : capture running / complete / all words read
//   Optional feature macro: CAPTURE_TEST_PATTERN_EN
module multi_chan_capture
    import capture_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int DATA_W = 14,
    parameter  int ADDR_W = 15,
    parameter  int OUT_W  = 16,
    localparam int CH_W   = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                     wrclk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] din,
    input  logic                     din_valid,
    input  logic                     load,
    input  logic                     rden,
    input  logic [CH_W-1:0]          rd_ch,
    input  logic                     rd_rewind,
    input  logic [1:0]               bw_bits,
`ifdef CAPTURE_TEST_PATTERN_EN
    input  logic                     test_mode,
`endif
    output logic [OUT_W-1:0]         dout,
    output logic                     dout_valid,
    output logic                     busy,
    output logic                     full,
    output logic                     rd_done
);

    localparam int P = OUT_W - DATA_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(2**ADDR_W - 1);

    state_e            st_q;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic              busy_q, full_q, rd_done_q;
    logic [1:0]        vld_pipe_q;    // [0]: RAM data ready, [1]: dout valid
    logic [CH_W-1:0]   ch_s1_q;
    logic [1:0]        bw_s1_q;
    logic [OUT_W-1:0]  dout_q;

    logic              we, rd_ok;
    logic [ADDR_W-1:0] rd_base;
    logic [DATA_W-1:0] rdata_arr [NUM_CH];
    logic [DATA_W-1:0] sel, flip;
    logic [OUT_W-1:0]  fmt_d;

    // load wins over rden in DONE; rewind lets a read through even after rd_done
    assign we      = (st_q == ST_CAPTURE) && din_valid && !load;
    assign rd_base = rd_rewind ? '0 : rd_addr_q;
    assign rd_ok   = (st_q == ST_DONE) && !load && rden && (!rd_done_q || rd_rewind);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] wdata;
`ifdef CAPTURE_TEST_PATTERN_EN
        assign wdata = test_mode ? DATA_W'(32'(wr_addr_q) + k) : din[k*DATA_W +: DATA_W];
`else
        assign wdata = din[k*DATA_W +: DATA_W];
`endif
        capture_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
            .clk   (wrclk),
            .we    (we),
            .waddr (wr_addr_q),
            .wdata (wdata),
            .re    (rd_ok),
            .raddr (rd_base),
            .rdata (rdata_arr[k])
        );
    end

    always_comb begin
        sel = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (ch_s1_q == CH_W'(k)) sel = rdata_arr[k];
        flip = {~sel[DATA_W-1], sel[DATA_W-2:0]};
        case (bw_s1_q)
            FMT_ZEXT:  fmt_d = OUT_W'(sel);
            FMT_SEXT:  fmt_d = OUT_W'($signed(sel));
            FMT_LJUST: fmt_d = OUT_W'(sel) << P;
            default:   fmt_d = OUT_W'($signed(flip));
        endcase
    end

    always_ff @(posedge wrclk or posedge rst) begin
        if (rst) begin
            st_q       <= ST_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            rd_done_q  <= 1'b0;
            vld_pipe_q <= '0;
            ch_s1_q    <= '0;
            bw_s1_q    <= '0;
            dout_q     <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], rd_ok};
            if (rd_ok) begin
                ch_s1_q <= rd_ch;
                bw_s1_q <= bw_bits;
            end
            if (vld_pipe_q[0]) dout_q <= fmt_d;

            case (st_q)
                ST_IDLE: if (load) begin
                    st_q      <= ST_CAPTURE;
                    wr_addr_q <= '0;
                    busy_q    <= 1'b1;
                end
                ST_CAPTURE: begin
                    if (load) begin
                        wr_addr_q <= '0;
                    end else if (din_valid) begin
                        wr_addr_q <= wr_addr_q + 1'b1;  // wraps to 0 after LAST
                        if (wr_addr_q == LAST) begin
                            st_q   <= ST_DONE;
                            busy_q <= 1'b0;
                            full_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (load) begin
                        st_q      <= ST_CAPTURE;
                        wr_addr_q <= '0;
                        busy_q    <= 1'b1;
                        full_q    <= 1'b0;
                        rd_done_q <= 1'b0;
                        rd_addr_q <= '0;
                    end else if (rd_ok) begin
                        rd_addr_q <= rd_base + 1'b1;
                        rd_done_q <= (rd_base == LAST);
                    end else if (rd_rewind) begin
                        rd_addr_q <= '0;
                        rd_done_q <= 1'b0;
                    end
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = vld_pipe_q[1];
    assign busy       = busy_q;
    assign full       = full_q;
    assign rd_done    = rd_done_q;

endmodule

// File: tb/tb_multi_chan_capture.sv
module tb_multi_chan_capture;

    localparam int NUM_CH = 2, DATA_W = 14, ADDR_W = 4, OUT_W = 16, DEPTH = 16;

    logic              wrclk = 0, rst = 1;
    logic [27:0]       din = '0;
    logic              din_valid = 0, load = 0, rden = 0, rd_rewind = 0;
    logic [0:0]        rd_ch = '0;
    logic [1:0]        bw_bits = '0;
    logic              test_mode = 0;
    logic [15:0]       dout;
    logic              dout_valid, busy, full, rd_done;

    multi_chan_capture #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) dut (
        .wrclk(wrclk), .rst(rst), .din(din), .din_valid(din_valid), .load(load),
        .rden(rden), .rd_ch(rd_ch), .rd_rewind(rd_rewind), .bw_bits(bw_bits),
`ifdef CAPTURE_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .dout(dout), .dout_valid(dout_valid), .busy(busy), .full(full), .rd_done(rd_done)
    );

    always #5 wrclk = ~wrclk;

    int ntest = 0, nfail = 0, cyc = 0;

    // behavioural model: phase 0 idle, 1 capturing, 2 done
    typedef struct { int t; logic [15:0] v; } ev_t;
    ev_t expq[$], gotq[$];
    int m_st = 0, wcnt = 0, rptr = 0;
    bit rdone = 0;
    logic [13:0] mem [2][DEPTH];

    function automatic logic [15:0] fmt(input logic [13:0] s, input logic [1:0] b);
        int v;
        v = int'(s);
        case (b)
            2'd0: return 16'(v);
            2'd1: return 16'((v >= 8192) ? v + 65536 - 16384 : v);
            2'd2: return 16'(v * 4);
            default: begin
                v = (v + 8192) % 16384;
                return 16'((v >= 8192) ? v + 65536 - 16384 : v);
            end
        endcase
    endfunction

    task automatic step();
        if (rst) begin
            m_st = 0; wcnt = 0; rptr = 0; rdone = 0;
        end else if (m_st == 1) begin
            if (load) wcnt = 0;
            else if (din_valid) begin
                for (int k = 0; k < 2; k++)
                    mem[k][wcnt] = test_mode ? 14'((wcnt + k) % 16384) : din[k*14 +: 14];
                wcnt++;
                if (wcnt == DEPTH) begin m_st = 2; wcnt = 0; end
            end
        end else if (load) begin
            m_st = 1; wcnt = 0; rptr = 0; rdone = 0;
        end else if (m_st == 2) begin
            if (rd_rewind) begin rptr = 0; rdone = 0; end
            if (rden && !rdone) begin
                expq.push_back('{cyc + 2, fmt(mem[rd_ch][rptr], bw_bits)});
                rptr++;
                if (rptr == DEPTH) begin rptr = 0; rdone = 1; end
            end
        end
        @(posedge wrclk); #1;
        cyc++;
        if (dout_valid) gotq.push_back('{cyc, dout});
    endtask

    function automatic logic [13:0] gen(input int kind, input int k, input int ch);
        if (kind == 0) return 14'(ch * 100 + k);
        if (kind == 2 && ch == 0 && k == 3) return 14'h2000;
        if (kind == 2 && ch == 0 && k == 4) return 14'h1FFF;
        return 14'($urandom);
    endfunction

    // stall: 0 always valid, 1 alternate (invalid first), 2 random
    task automatic run_capture(input int kind, input int stall, input int restart_at, output int bcnt);
        int k, j;
        bit restarted, ld;
        k = 0; j = 0; restarted = 0;
        load = 1; din_valid = 0; step(); load = 0;
        bcnt = int'(busy);
        while (busy && j < 200) begin
            if (!restarted && k == restart_at) begin load = 1; restarted = 1; k = 0; end
            din_valid = (stall == 0) ? 1'b1 : (stall == 1) ? 1'(j % 2) : 1'($urandom % 2);
            for (int c = 0; c < 2; c++) din[c*14 +: 14] = gen(kind, k, c);
            ld = load;
            step();
            load = 0;
            if (din_valid && !ld) k++;
            j++;
            bcnt += int'(busy);
        end
        din_valid = 0;
        ntest++;
        if (j >= 200) begin nfail++; $display("FAIL capture_timeout busy still %b after %0d cycles", busy, j); end
    endtask

    task automatic rd_burst(input int n, input int ch, input int bw, input bit rew, input bit rnd);
        for (int i = 0; i < n; i++) begin
            rden = 1; rd_rewind = rew && (i == 0);
            rd_ch = rnd ? 1'($urandom % 2) : 1'(ch);
            bw_bits = rnd ? 2'($urandom % 4) : 2'(bw);
            step();
        end
        rden = 0; rd_rewind = 0;
        step(); step(); step();
    endtask

    task automatic test_reset();
        rst = 1; step(); step(); rst = 0; step();
        ntest += 5;
        if (dout !== 16'h0)    begin nfail++; $display("FAIL reset_dout got %h want 0000", dout); end
        if (dout_valid !== 0)  begin nfail++; $display("FAIL reset_dout_valid got %b want 0", dout_valid); end
        if (busy !== 0)        begin nfail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (full !== 0)        begin nfail++; $display("FAIL reset_full got %b want 0", full); end
        if (rd_done !== 0)     begin nfail++; $display("FAIL reset_rd_done got %b want 0", rd_done); end
    endtask

    task automatic test_capture_fill();
        int bc;
        run_capture(0, 0, -1, bc);
        ntest += 3;
        if (bc != 16)     begin nfail++; $display("FAIL fill_busy_cycles got %0d want 16", bc); end
        if (full !== 1)   begin nfail++; $display("FAIL fill_full got %b want 1", full); end
        if (busy !== 0)   begin nfail++; $display("FAIL fill_busy_end got %b want 0", busy); end
    endtask

    task automatic test_readout();
        int t0;
        expq.delete(); gotq.delete();
        t0 = cyc;
        rd_burst(17, 1, 0, 0, 0);
        ntest += 6;
        if (gotq.size() != 16) begin nfail++; $display("FAIL readout_count got %0d want 16", gotq.size()); end
        if (gotq.size() > 0 && (gotq[0].v !== 16'd100 || gotq[0].t != t0 + 2)) begin
            nfail++; $display("FAIL readout_first got v=%0d t=%0d want v=100 t=%0d", gotq[0].v, gotq[0].t, t0 + 2); end
        if (gotq.size() == 16 && gotq[15].v !== 16'd115) begin
            nfail++; $display("FAIL readout_last got %0d want 115", gotq[15].v); end
        if (rd_done !== 1)     begin nfail++; $display("FAIL readout_rd_done got %b want 1", rd_done); end
        if (dout_valid !== 0)  begin nfail++; $display("FAIL readout_17th_valid got %b want 0", dout_valid); end
        if (dout !== 16'd115)  begin nfail++; $display("FAIL readout_hold got %0d want 115", dout); end
        foreach (expq[i]) begin
            ntest++;
            if (i >= gotq.size() || gotq[i].t != expq[i].t || gotq[i].v !== expq[i].v) begin
                nfail++; $display("FAIL readout_word[%0d] got %h want %h@%0d", i, (i < gotq.size()) ? gotq[i].v : 16'hx, expq[i].v, expq[i].t); end
        end
    endtask

    task automatic test_formats();
        int bc;
        logic [15:0] want [4];
        want[0] = 16'h2000; want[1] = 16'hE000; want[2] = 16'h8000; want[3] = 16'h0000;
        run_capture(2, 0, -1, bc);
        for (int b = 0; b < 5; b++) begin
            expq.delete(); gotq.delete();
            rd_burst(16, 0, b % 4, 1, b == 4);
            ntest++;
            if (gotq.size() != expq.size()) begin nfail++; $display("FAIL fmt_count[%0d] got %0d want %0d", b, gotq.size(), expq.size()); end
            if (b < 4 && gotq.size() > 4) begin
                ntest++;
                if (gotq[3].v !== want[b]) begin nfail++; $display("FAIL fmt_2000_bw%0d got %h want %h", b, gotq[3].v, want[b]); end
                if (b == 3) begin
                    ntest++;
                    if (gotq[4].v !== 16'hFFFF) begin nfail++; $display("FAIL fmt_1fff_bw3 got %h want ffff", gotq[4].v); end
                end
            end
            foreach (expq[i]) begin
                ntest++;
                if (i >= gotq.size() || gotq[i].t != expq[i].t || gotq[i].v !== expq[i].v) begin
                    nfail++; $display("FAIL fmt_word[%0d][%0d] got %h want %h", b, i, (i < gotq.size()) ? gotq[i].v : 16'hx, expq[i].v); end
            end
        end
    endtask

    task automatic test_stalls();
        int bc;
        for (int s = 1; s < 3; s++) begin
            run_capture(1, s, -1, bc);
            if (s == 1) begin
                ntest++;
                if (bc != 32) begin nfail++; $display("FAIL stall_busy_cycles got %0d want 32", bc); end
            end
            for (int ch = 0; ch < 3; ch++) begin
                expq.delete(); gotq.delete();
                rd_burst(16, ch % 2, $urandom % 4, 1, ch == 2);
                foreach (expq[i]) begin
                    ntest++;
                    if (i >= gotq.size() || gotq[i].t != expq[i].t || gotq[i].v !== expq[i].v) begin
                        nfail++; $display("FAIL stall_word[%0d][%0d] got %h want %h", s, i, (i < gotq.size()) ? gotq[i].v : 16'hx, expq[i].v); end
                end
            end
        end
    endtask

    task automatic test_restarts();
        int bc;
        // load at write 7: second pass overwrites from address 0
        run_capture(1, 0, 7, bc);
        ntest++;
        if (bc != 24) begin nfail++; $display("FAIL restart_busy_cycles got %0d want 24", bc); end
        for (int ch = 0; ch < 2; ch++) begin
            expq.delete(); gotq.delete();
            rd_burst(16, ch, 1, 1, 0);
            foreach (expq[i]) begin
                ntest++;
                if (i >= gotq.size() || gotq[i].t != expq[i].t || gotq[i].v !== expq[i].v) begin
                    nfail++; $display("FAIL restart_word[%0d][%0d] got %h want %h", ch, i, (i < gotq.size()) ? gotq[i].v : 16'hx, expq[i].v); end
            end
        end
        // load together with rden: in-flight reads still land, the new rden is dropped
        expq.delete(); gotq.delete();
        rden = 1; rd_ch = 1; bw_bits = 0; rd_rewind = 1; step(); rd_rewind = 0; step(); step();
        load = 1; step(); load = 0; rden = 0; step(); step(); step();
        ntest += 2;
        if (gotq.size() != 3) begin nfail++; $display("FAIL load_rden_count got %0d want 3", gotq.size()); end
        if (busy !== 1)       begin nfail++; $display("FAIL load_rden_busy got %b want 1", busy); end
        foreach (expq[i]) begin
            ntest++;
            if (i >= gotq.size() || gotq[i].v !== expq[i].v) begin
                nfail++; $display("FAIL load_rden_word[%0d] got %h want %h", i, (i < gotq.size()) ? gotq[i].v : 16'hx, expq[i].v); end
        end
        // rewind after rd_done
        run_capture(1, 0, -1, bc);
        rd_burst(16, 1, 0, 0, 0);
        ntest++;
        if (rd_done !== 1) begin nfail++; $display("FAIL rewind_pre_done got %b want 1", rd_done); end
        expq.delete(); gotq.delete();
        rd_burst(4, 1, 0, 1, 0);
        ntest += 2;
        if (gotq.size() != 4) begin nfail++; $display("FAIL rewind_count got %0d want 4", gotq.size()); end
        if (gotq.size() > 0 && gotq[0].v !== {2'b00, mem[1][0]}) begin
            nfail++; $display("FAIL rewind_addr0 got %h want %h", gotq[0].v, {2'b00, mem[1][0]}); end
        foreach (expq[i]) begin
            ntest++;
            if (i >= gotq.size() || gotq[i].t != expq[i].t || gotq[i].v !== expq[i].v) begin
                nfail++; $display("FAIL rewind_word[%0d] got %h want %h", i, (i < gotq.size()) ? gotq[i].v : 16'hx, expq[i].v); end
        end
        // rst in the middle of a read burst
        rden = 1; rd_rewind = 1; rd_ch = 0; bw_bits = 0; step(); rd_rewind = 0; step(); step(); step();
        ntest++;
        if (dout_valid !== 1) begin nfail++; $display("FAIL rst_pre_valid got %b want 1", dout_valid); end
        rst = 1; #1;
        ntest += 4;
        if (dout_valid !== 0) begin nfail++; $display("FAIL rst_dout_valid got %b want 0", dout_valid); end
        if (full !== 0)       begin nfail++; $display("FAIL rst_full got %b want 0", full); end
        if (dout !== 16'h0)   begin nfail++; $display("FAIL rst_dout got %h want 0000", dout); end
        if (rd_done !== 0)    begin nfail++; $display("FAIL rst_rd_done got %b want 0", rd_done); end
        rden = 0; step(); rst = 0; step();
        expq.delete(); gotq.delete();
    endtask

`ifdef CAPTURE_TEST_PATTERN_EN
    task automatic test_pattern();
        int bc;
        test_mode = 1;
        run_capture(1, 2, -1, bc);
        test_mode = 0;
        expq.delete(); gotq.delete();
        rd_burst(16, 1, 0, 1, 0);
        ntest++;
        if (gotq.size() < 6 || gotq[5].v !== 16'd6) begin
            nfail++; $display("FAIL pattern_ch1_addr5 got %h want 0006", (gotq.size() > 5) ? gotq[5].v : 16'hx); end
        foreach (expq[i]) begin
            ntest++;
            if (i >= gotq.size() || gotq[i].v !== expq[i].v) begin
                nfail++; $display("FAIL pattern_word[%0d] got %h want %h", i, (i < gotq.size()) ? gotq[i].v : 16'hx, expq[i].v); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_capture_fill();
        test_readout();
        test_formats();
        test_stalls();
        test_restarts();
`ifdef CAPTURE_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
